// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU a restoring divider,
// one bit per cycle. MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   op_valid  operation request, sampled at the clock edge
//   op        000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO,
//             11x reserved (ignored)
//   a         rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b         rt operand (multiplier / divisor)
//   busy      high while a mul/div is in flight
//   done      one-cycle pulse when a mul/div result lands in HI/LO
//   hi, lo    architectural HI and LO
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic               is_div;     // latched operation class
    logic               neg_q;      // sign of product / quotient
    logic               neg_r;      // sign of remainder
    logic               div_zero;   // divide by zero: skip sign fix
    logic [WIDTH-1:0]   acc;        // product upper half / remainder
    logic [WIDTH-1:0]   low;        // multiplier->product lower half / dividend->quotient
    logic [WIDTH-1:0]   opnd;       // multiplicand / divisor magnitude
    logic [CW-1:0]      cnt;

    // Operand magnitudes; op[0] marks the signed variants. The most negative
    // value negates to itself, which is the correct unsigned magnitude.
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // One iteration of the shared datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   acc_n, low_n;

    // Sign fix-up applied on the FIX edge
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // NOTE: every signal assigned in always_comb gets a value before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sgn_a = op[0] & a[WIDTH-1];
        sgn_b = op[0] & b[WIDTH-1];
        mag_a = sgn_a ? -a : a;
        mag_b = sgn_b ? -b : b;

        mul_sum = {1'b0, acc} + {1'b0, opnd};
        // 33-bit compare so the bit shifted out of the remainder is kept
        rem_sh  = {acc, low[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opnd};
        // Only taken when rem_sh >= opnd, so the difference fits in WIDTH bits
        rem_sub = rem_sh[WIDTH-1:0] - opnd;

        acc_n = acc;
        low_n = low;
        if (is_div) begin
            acc_n = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            low_n = {low[WIDTH-2:0], rem_ge};
        end else if (low[0]) begin
            acc_n = mul_sum[WIDTH:1];
            low_n = {mul_sum[0], low[WIDTH-1:1]};
        end else begin
            acc_n = {1'b0, acc[WIDTH-1:1]};
            low_n = {acc[0], low[WIDTH-1:1]};
        end

        prod     = {acc, low};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -low : low;
        r_fix    = neg_r ? -acc : acc;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too; they are few and a
        // clean reset keeps the aborted-operation case free of stale data.
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && !busy) begin
                        case (op)
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                is_div   <= op[1];
                                neg_q    <= sgn_a ^ sgn_b;
                                neg_r    <= sgn_a;
                                div_zero <= op[1] && (b == '0);
                                acc      <= '0;
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= RUN;
                                if (op[1]) begin
                                    // With a zero divisor every step subtracts
                                    // nothing, so the raw dividend ends up in
                                    // acc and the quotient becomes all ones.
                                    low  <= (b == '0) ? a : mag_a;
                                    opnd <= mag_b;
                                end else begin
                                    low  <= mag_b;
                                    opnd <= mag_a;
                                end
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    low <= low_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= acc;
                        lo <= low;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide responder that owns the architectural HI/LO registers. It replaces single-cycle combinational MULT/DIV in the datapath. The controller issues MULT, MULTU, DIV, DIVU, MTHI or MTLO with a valid/busy handshake, stalls while busy, and reads HI/LO for MFHI/MFLO. The block uses a shift-add multiplier and a restoring divider, one bit per cycle.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request, sampled at clk edge
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved (ignored)
a  input  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
b  input  32  rt operand (multiplier / divisor)
busy  output  1  high while a mul/div is in flight; controller must stall HI/LO users
done  output  1  one-cycle pulse when a mul/div result is written to HI/LO
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset dominates any other input on the same edge and aborts an in-flight operation; its partial result is discarded.
- States: IDLE, RUN, FIX.
- Acceptance: a request is accepted on an edge where op_valid=1, busy=0 and state=IDLE. op_valid while busy=1 is ignored (not queued). Reserved op values are ignored.
- MTHI/MTLO: on the accept edge, hi<=a (MTHI) or lo<=a (MTLO). No busy, no done. The new value is visible the cycle after the accept edge.
- MULT/DIV accept edge:
  - Latch the operation type.
  - Latch the operand magnitudes: for signed ops, |x| as 32-bit unsigned (0x80000000 stays 0x80000000); for unsigned ops, the raw value.
  - Latch the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31]. All signs are 0 for unsigned ops.
  - Clear the 64-bit accumulator and the 6-bit counter. Go to RUN. busy=1 from the next cycle.
- RUN: exactly 32 cycles, one iteration per edge.
  - Multiply: if the current multiplier LSB=1, add the multiplicand into the upper half; shift the 64-bit {acc,multiplier} right by 1.
  - Divide (restoring): shift {rem,quot} left by 1; if rem >= divisor, subtract the divisor and set the quotient LSB.
  - The subtract/compare is 33 bits wide so no carry is lost.
  - After the 32nd iteration, go to FIX.
- FIX: one edge. Apply two's-complement negation where the latched sign=1: the 64-bit product, the 32-bit quotient and the 32-bit remainder. Write hi/lo:
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: hi=remainder, lo=quotient.
  - busy<=0 and done<=1 on this edge; go to IDLE.
- Latency: accept edge E0; busy is high for the 33 cycles after E0; hi/lo update and done pulses after edge E33. A new request may be accepted in the same cycle done is high.
- hi/lo hold their old values throughout RUN. Partial results are never visible on hi/lo.
- Divide semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero, DIV or DIVU, fixed by design: hi=a (original, un-negated), lo=0xFFFFFFFF. Detect b==0 at accept, still take the full 33 cycles, and bypass the sign fix in FIX.
- done is low in every cycle except the single pulse cycle.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for exactly 33 cycles, then done=1 for 1 cycle, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/0 -> hi=0x64, lo=0xFFFFFFFF after 33 busy cycles.
- MTHI 0x12345678 when idle -> hi=0x12345678 next cycle, busy stays 0. Then issue MULTU and assert MTLO 0xAAAA during busy -> request ignored, lo unchanged until FIX.
- Start DIVU 1000/3; assert reset at busy cycle 10 -> next cycle busy=0, done=0, hi=lo=0; a following MULTU 6x7 gives lo=42, hi=0.
